ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage. It sits between the ID/EX pipeline register and the EX/MEM register. It resolves RAW hazards by forwarding from the MEM and WB stages, then computes the ALU result. Multiply is single-cycle. Divide and remainder use an iterative restoring divider that holds the pipeline through a stall request.

Parameters:
DATA_W, 32, datapath width; divider iteration count equals DATA_W
STALL_IDX, 3, index of the stall bit that holds the EX/MEM register; used to hold a finished divide result

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  6  global stall vector; only bit STALL_IDX is used
exALUop  in  5  operation code
exReg1  in  DATA_W  rs1 value read in ID
exReg2  in  DATA_W  rs2 value read in ID
exRS1  in  5  rs1 index
exRS2  in  5  rs2 index
exWriteNum  in  5  destination register index
exWriteReg  in  1  destination write enable
memWriteReg  in  1  MEM-stage write enable
memWriteNum  in  5  MEM-stage destination index
memResult  in  DATA_W  MEM-stage result
wbWriteReg  in  1  WB-stage write enable
wbWriteNum  in  5  WB-stage destination index
wbResult  in  DATA_W  WB-stage result
exResult  out  DATA_W  result to the EX/MEM register
exWriteNumOut  out  5  destination index, passed through
exWriteRegOut  out  1  write enable; forced to 0 while stallreq=1
stallreq  out  1  request to stall the ID/EX stage and the stages upstream of it

Behaviour:
- Reset: divider FSM goes to IDLE; counter, quotient and remainder registers clear to 0. While rst=1: exResult=0, exWriteRegOut=0, stallreq=0.
- Operand forwarding (combinational), applied to each operand independently:
  - Select memResult if memWriteReg=1, memWriteNum==RSx and RSx!=0.
  - Otherwise select wbResult if wbWriteReg=1, wbWriteNum==RSx and RSx!=0.
  - Otherwise select exRegx.
  - MEM has priority over WB.
- Op codes (combinational result unless noted):
  - 0 NOP = 0; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA: shift amount is op2[4:0].
  - 9 SLT (signed), 10 SLTU (unsigned).
  - 11 MUL: low DATA_W bits of the product.
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU: divider, see below.
  - 16–31: result = 0.
  - Arithmetic wraps modulo 2^DATA_W.
- Divider FSM: states IDLE, BUSY, DONE.
  - IDLE with op in 12–15: in this cycle (T), latch operand magnitudes (absolute values for the signed ops), the sign-fix flags and the op code. Set counter=0, go to BUSY. stallreq=1 combinationally in cycle T.
  - BUSY: one restoring iteration per cycle; counter increments; stallreq=1. When counter==DATA_W-1, go to DONE.
  - DONE: exResult = sign-corrected quotient or remainder; stallreq=0.
    - Stay in DONE while stall[STALL_IDX]=1.
    - Go to IDLE the first cycle stall[STALL_IDX]=0, so the same instruction is not re-issued.
  - Timing: stallreq is high in cycles T..T+DATA_W (DATA_W+1 cycles); the result is valid at T+DATA_W+1.
- Signed result rules:
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Divide by 0: quotient = all ones, remainder = dividend.
  - Overflow (most-negative / -1): quotient = most-negative, remainder = 0.
- Forwarded operands are captured only at divide start. Later changes on memResult/wbResult do not affect an in-flight divide.
- exWriteNumOut always equals exWriteNum.
- exWriteRegOut = exWriteReg, except 0 while stallreq=1.
- rst during BUSY or DONE aborts the divide: next cycle is IDLE, stallreq=0.

Optional Feature:
EX_DIV_SHORTCUT_EN
- Defined: a divisor of 0, or signed overflow, is detected in IDLE. The FSM goes straight to DONE with the special-case result. stallreq is high for cycle T only, and the result is valid at T+1.
- Undefined: special cases run the full DATA_W iterations. The final values are identical either way.

Test Plan:
- ADD with exRS1=5, memWriteReg=1, memWriteNum=5, memResult=10, wbWriteNum=5, wbResult=99, exReg2=3 -> exResult=13 (MEM wins over WB).
- exRS1=0, memWriteReg=1, memWriteNum=0, memResult=7, exReg1=4, exReg2=1, ADD -> exResult=5 (register 0 is never forwarded).
- DIVU 100/7 -> stallreq high exactly 33 cycles, then exResult=14; REMU 100/7 -> 2; exWriteRegOut=0 throughout the stall.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000; DIVU 5/0 -> 0xFFFFFFFF.
- DIVU 5/0 with EX_DIV_SHORTCUT_EN defined -> stallreq high for 1 cycle, result 0xFFFFFFFF; without the macro -> high for 33 cycles, same result.
- Divide finishes with stall[3]=1 for 4 cycles -> result held in DONE, no restart, stallreq stays 0; rst asserted mid-BUSY -> next cycle stallreq=0, FSM in IDLE.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: MEM/WB operand forwarding, single-cycle ALU and multiply, iterative restoring divider.
// Optional: define EX_DIV_SHORTCUT_EN to resolve divide-by-zero and signed overflow without iterating.
module ex_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STALL_IDX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [4:0]        exALUop,
  input  logic [DATA_W-1:0] exReg1,
  input  logic [DATA_W-1:0] exReg2,
  input  logic [4:0]        exRS1,
  input  logic [4:0]        exRS2,
  input  logic [4:0]        exWriteNum,
  input  logic              exWriteReg,
  input  logic              memWriteReg,
  input  logic [4:0]        memWriteNum,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbWriteReg,
  input  logic [4:0]        wbWriteNum,
  input  logic [DATA_W-1:0] wbResult,
  output logic [DATA_W-1:0] exResult,
  output logic [4:0]        exWriteNumOut,
  output logic              exWriteRegOut,
  output logic              stallreq
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [4:0] OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,  OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,  OP_SRA  = 5'd8;
  localparam logic [4:0] OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_MUL  = 5'd11, OP_DIV  = 5'd12;
  localparam logic [4:0] OP_DIVU = 5'd13, OP_REM  = 5'd14, OP_REMU = 5'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t state, next_state;

  logic [DATA_W-1:0] op1, op2, alu_res;
  logic [DATA_W-1:0] quo, rem, dsr;
  logic [CNT_W-1:0]  cnt;
  logic              want_q, neg_q, neg_r, div0;
  logic              start;
  logic              unused_stall;

  assign unused_stall = ^stall;

  // Forwarding: MEM beats WB, register 0 is never forwarded
  always_comb begin : fwd
    op1 = exReg1;
    if (memWriteReg && memWriteNum == exRS1 && exRS1 != 5'd0)    op1 = memResult;
    else if (wbWriteReg && wbWriteNum == exRS1 && exRS1 != 5'd0) op1 = wbResult;
    op2 = exReg2;
    if (memWriteReg && memWriteNum == exRS2 && exRS2 != 5'd0)    op2 = memResult;
    else if (wbWriteReg && wbWriteNum == exRS2 && exRS2 != 5'd0) op2 = wbResult;
  end

  always_comb begin : alu
    alu_res = '0;
    case (exALUop)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLL:  alu_res = op1 << op2[4:0];
      OP_SRL:  alu_res = op1 >> op2[4:0];
      OP_SRA:  alu_res = DATA_W'($signed(op1) >>> op2[4:0]);
      OP_SLT:  alu_res = DATA_W'($signed(op1) < $signed(op2));
      OP_SLTU: alu_res = DATA_W'(op1 < op2);
      OP_MUL:  alu_res = op1 * op2;
      default: alu_res = '0;
    endcase
  end

  logic              is_div, is_signed, a_neg, b_neg, start_div0;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign is_div     = (exALUop == OP_DIV) || (exALUop == OP_DIVU) ||
                      (exALUop == OP_REM) || (exALUop == OP_REMU);
  assign is_signed  = (exALUop == OP_DIV) || (exALUop == OP_REM);
  assign a_neg      = is_signed & op1[DATA_W-1];
  assign b_neg      = is_signed & op2[DATA_W-1];
  assign a_mag      = a_neg ? -op1 : op1;
  assign b_mag      = b_neg ? -op2 : op2;
  assign start_div0 = (op2 == '0);

`ifdef EX_DIV_SHORTCUT_EN
  logic start_ovf;
  assign start_ovf = is_signed && (op1 == {1'b1, {(DATA_W-1){1'b0}}}) && (op2 == '1);
`endif

  // One restoring step: shift next dividend bit into the partial remainder
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] rem_sub, rem_nx;
  logic              fits;

  assign rem_sh  = {rem, quo[DATA_W-1]};
  assign fits    = rem_sh >= {1'b0, dsr};
  assign rem_sub = DATA_W'(rem_sh - {1'b0, dsr});
  assign rem_nx  = fits ? rem_sub : rem_sh[DATA_W-1:0];

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin : fsm
    next_state = state;
    stallreq   = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: if (is_div) begin
        stallreq   = 1'b1;
        start      = 1'b1;
        next_state = BUSY;
`ifdef EX_DIV_SHORTCUT_EN
        if (start_div0 || start_ovf) next_state = DONE;
`endif
      end
      BUSY: begin
        stallreq = 1'b1;
        if (cnt == CNT_LAST) next_state = DONE;
      end
      DONE: if (!stall[STALL_IDX]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) begin
      stallreq = 1'b0;
      start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : div_regs
    if (rst) begin
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dsr    <= '0;
      want_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      dsr    <= b_mag;
      want_q <= (exALUop == OP_DIV) || (exALUop == OP_DIVU);
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0   <= start_div0;
      quo    <= a_mag;
      rem    <= '0;
`ifdef EX_DIV_SHORTCUT_EN
      if (start_div0) begin
        quo <= '1;
        rem <= a_mag;
      end else if (start_ovf) begin
        quo <= {1'b1, {(DATA_W-1){1'b0}}};
      end
`endif
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      quo <= {quo[DATA_W-2:0], fits};
      rem <= rem_nx;
    end
  end

  logic [DATA_W-1:0] q_fix, r_fix, div_res;

  assign q_fix   = div0 ? '1 : (neg_q ? -quo : quo);
  assign r_fix   = neg_r ? -rem : rem;
  assign div_res = want_q ? q_fix : r_fix;

  assign exResult      = rst ? '0 : ((state == DONE) ? div_res : alu_res);
  assign exWriteNumOut = exWriteNum;
  assign exWriteRegOut = !rst && exWriteReg && !stallreq;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU and divide traffic vs. a reference model.
module tb_ex_stage;

  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [4:0]  NOP = 5'd0, ADD = 5'd1, DIV = 5'd12, DIVU = 5'd13, REM = 5'd14, REMU = 5'd15;

  logic        clk, rst;
  logic [5:0]  stall;
  logic [4:0]  exALUop, exRS1, exRS2, exWriteNum, memWriteNum, wbWriteNum, exWriteNumOut;
  logic [31:0] exReg1, exReg2, memResult, wbResult, exResult;
  logic        exWriteReg, memWriteReg, wbWriteReg, exWriteRegOut, stallreq;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DATA_W(32), .STALL_IDX(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .exALUop(exALUop),
    .exReg1(exReg1), .exReg2(exReg2), .exRS1(exRS1), .exRS2(exRS2),
    .exWriteNum(exWriteNum), .exWriteReg(exWriteReg),
    .memWriteReg(memWriteReg), .memWriteNum(memWriteNum), .memResult(memResult),
    .wbWriteReg(wbWriteReg), .wbWriteNum(wbWriteNum), .wbResult(wbResult),
    .exResult(exResult), .exWriteNumOut(exWriteNumOut),
    .exWriteRegOut(exWriteRegOut), .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: operand select and per-op result from plain arithmetic
  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rv,
                                          input logic mw, input logic [4:0] mn, input logic [31:0] mr,
                                          input logic ww, input logic [4:0] wn, input logic [31:0] wr);
    if (rs != 0 && mw && mn == rs) return mr;
    if (rs != 0 && ww && wn == rs) return wr;
    return rv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint unsigned prod;
    sa = a;
    sb = b;
    prod = longint'(a) * longint'(b);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return a << b[4:0];
      7: return a >> b[4:0];
      8: return 32'(sa >>> b[4:0]);
      9: return (sa < sb) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      11: return prod[31:0];
      12: return (b == 0) ? 32'hFFFF_FFFF : (a == MIN && sb == -1) ? MIN : 32'(sa / sb);
      13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      14: return (b == 0) ? a : (a == MIN && sb == -1) ? 32'd0 : 32'(sa % sb);
      15: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_DIV_SHORTCUT_EN
    if (b == 0) return 1;
    if ((op == DIV || op == REM) && a == MIN && b == 32'hFFFF_FFFF) return 1;
`endif
    return (op == 5'd255) ? 0 : 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    exALUop = NOP; exRS1 = 0; exRS2 = 0; exReg1 = 0; exReg2 = 0;
    memWriteReg = 0; wbWriteReg = 0; memWriteNum = 0; wbWriteNum = 0;
    memResult = 0; wbResult = 0; exWriteReg = 1; exWriteNum = 5'd7;
  endtask

  // Inputs of a divide are already applied; follow it through stall, DONE hold and release
  task automatic finish_div(input string tag, input logic [31:0] exp_res, input int exp_cyc,
                            input int hold, input bit scramble);
    int n;
    n = 0;
    #1;
    while (stallreq === 1'b1 && n < 200) begin
      chk({tag, " wr_gated"}, 32'(exWriteRegOut), 32'h0);
      n++;
      @(posedge clk); #1;
      if (scramble) begin memResult = $urandom; wbResult = $urandom; end
      #1;
    end
    chk({tag, " stall_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, " result"}, exResult, exp_res);
    chk({tag, " wr_done"}, 32'(exWriteRegOut), 32'(exWriteReg));
    for (int i = 0; i < hold; i++) begin
      stall[3] = 1'b1;
      @(posedge clk); #2;
      chk({tag, " hold_stallreq"}, 32'(stallreq), 32'h0);
      chk({tag, " hold_result"}, exResult, exp_res);
    end
    stall[3] = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk({tag, " idle_stallreq"}, 32'(stallreq), 32'h0);
    chk({tag, " idle_result"}, exResult, 32'h0);
  endtask

  task automatic do_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exALUop = op; exReg1 = a; exReg2 = b; exRS1 = 0; exRS2 = 0;
    finish_div(tag, ref_alu(op, a, b), ref_cycles(op, a, b), hold, 1'b0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, fa, fb;
    int          mode;

    idle_inputs();
    stall = 6'b000000;
    rst = 1'b1;
    exALUop = ADD; exReg1 = 32'd9; exReg2 = 32'd4;
    repeat (2) @(posedge clk);
    #2;
    chk("reset result", exResult, 32'h0);
    chk("reset wr", 32'(exWriteRegOut), 32'h0);
    chk("reset stallreq", 32'(stallreq), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    // MEM wins over WB
    exALUop = ADD; exRS1 = 5; exReg1 = 32'd1; exReg2 = 32'd3;
    memWriteReg = 1; memWriteNum = 5; memResult = 32'd10;
    wbWriteReg = 1; wbWriteNum = 5; wbResult = 32'd99;
    #1;
    chk("fwd mem_priority", exResult, 32'd13);
    chk("fwd writenum", 32'(exWriteNumOut), 32'd7);
    @(posedge clk); #1;
    idle_inputs();

    // r0 is never forwarded
    exALUop = ADD; exRS1 = 0; exReg1 = 32'd4; exReg2 = 32'd1;
    memWriteReg = 1; memWriteNum = 0; memResult = 32'd7;
    #1;
    chk("fwd r0", exResult, 32'd5);
    @(posedge clk); #1;
    idle_inputs();

    do_div("divu_100_7", DIVU, 32'd100, 32'd7, 0);
    do_div("remu_100_7", REMU, 32'd100, 32'd7, 0);
    do_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 0);
    do_div("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 0);
    do_div("div_ovf", DIV, MIN, 32'hFFFF_FFFF, 0);
    do_div("rem_ovf", REM, MIN, 32'hFFFF_FFFF, 0);
    do_div("divu_by0", DIVU, 32'd5, 32'd0, 0);
    do_div("rem_by0_neg", REM, 32'hFFFF_FF00, 32'd0, 0);
    do_div("div_by0_neg", DIV, 32'hFFFF_FF00, 32'd0, 0);
    do_div("div_hold", DIV, 32'd1000, 32'hFFFF_FFFD, 4);

    // Reset aborts an in-flight divide
    exALUop = DIVU; exReg1 = 32'd1000; exReg2 = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort rst_stallreq", 32'(stallreq), 32'h0);
    chk("abort rst_result", exResult, 32'h0);
    chk("abort rst_wr", 32'(exWriteRegOut), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("abort idle_stallreq", 32'(stallreq), 32'h0);
    @(posedge clk); #1;
    do_div("after_abort", DIVU, 32'd1000, 32'd3, 0);

    // Randomized single-cycle ops with random forwarding hazards
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op >= 12 && op <= 15) op = 5'($urandom_range(0, 11));
      exALUop = op;
      exReg1 = $urandom; exReg2 = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exRS1 = 5'($urandom_range(0, 3)); exRS2 = 5'($urandom_range(0, 3));
      memWriteReg = 1'($urandom_range(0, 1)); memWriteNum = 5'($urandom_range(0, 3)); memResult = $urandom;
      wbWriteReg = 1'($urandom_range(0, 1)); wbWriteNum = 5'($urandom_range(0, 3)); wbResult = $urandom;
      exWriteReg = 1'($urandom_range(0, 1)); exWriteNum = 5'($urandom);
      a = ref_fwd(exRS1, exReg1, memWriteReg, memWriteNum, memResult, wbWriteReg, wbWriteNum, wbResult);
      b = ref_fwd(exRS2, exReg2, memWriteReg, memWriteNum, memResult, wbWriteReg, wbWriteNum, wbResult);
      #1;
      chk($sformatf("rand_alu%0d op%0d", i, op), exResult, ref_alu(op, a, b));
      chk($sformatf("rand_alu%0d wr", i), 32'(exWriteRegOut), 32'(exWriteReg));
      chk($sformatf("rand_alu%0d num", i), 32'(exWriteNumOut), 32'(exWriteNum));
      chk($sformatf("rand_alu%0d stallreq", i), 32'(stallreq), 32'h0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Randomized divides with forwarded operands that change after capture
    for (int i = 0; i < 10; i++) begin
      op = 5'(12 + $urandom_range(0, 3));
      mode = $urandom_range(0, 4);
      fa = (mode == 4) ? MIN : $urandom;
      case (mode)
        0: fb = 32'd0;
        1: fb = 32'($urandom_range(1, 20));
        2: fb = $urandom;
        default: fb = 32'hFFFF_FFFF;
      endcase
      stall = 6'($urandom) & 6'b110111;
      exALUop = op; exReg1 = $urandom; exReg2 = $urandom;
      exRS1 = 5'd1; exRS2 = 5'd2;
      memWriteReg = 1; memWriteNum = 5'd1; memResult = fa;
      wbWriteReg = 1; wbWriteNum = 5'd2; wbResult = fb;
      finish_div($sformatf("rand_div%0d op%0d", i, op), ref_alu(op, fa, fb),
                 ref_cycles(op, fa, fb), i % 3, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
